// File: rtl/regfile_clr.sv
// Parametrised register file: one decoded write port, two registered read ports,
// optional hardwired-zero register 0, optional write-to-read bypass and a bulk-clear sweep.
module regfile_clr #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done
);

    localparam int DEPTH = 2**ADDR_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  wen_s;
    logic [DEPTH-1:0]  clr_s;
    logic              wr_fire_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;
    logic [DATA_W-1:0] rdata_a_r;
    logic [DATA_W-1:0] rdata_b_r;

    assign wr_ready  = (state_r == ST_IDLE);
    assign wr_fire_s = we & wr_ready;
    assign busy      = (state_r == ST_CLEAR);
    assign clr_done  = (state_r == ST_DONE);
    assign rdata_a   = rdata_a_r;
    assign rdata_b   = rdata_b_r;

    // Next-state logic of the clear sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_start) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_r == {ADDR_W{1'b1}}) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sweep pointer: held at zero outside CLEAR so every sweep starts at register 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {ADDR_W{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            cnt_r <= cnt_r + ADDR_W'(1);
        end else begin
            cnt_r <= {ADDR_W{1'b0}};
        end
    end

    // One-hot write and clear enables; register 0 never takes writes when hardwired
    always_comb begin
        wen_s = {DEPTH{1'b0}};
        clr_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            wen_s[i] = wr_fire_s && (waddr == ADDR_W'(i)) && ((ZERO_REG == 0) || (i != 0));
            clr_s[i] = (state_r == ST_CLEAR) && (cnt_r == ADDR_W'(i));
        end
    end

    // Storage array; clear and write never coincide since writes are only accepted in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_s[i]) begin
                    mem_r[i] <= {DATA_W{1'b0}};
                end else if (wen_s[i]) begin
                    mem_r[i] <= wdata;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Read-port A select: zero register, then bypass, then array contents
    always_comb begin
        rd_a_s = mem_r[raddr_a];
        if ((ZERO_REG != 0) && (raddr_a == {ADDR_W{1'b0}})) begin
            rd_a_s = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && wr_fire_s && (raddr_a == waddr)) begin
            rd_a_s = wdata;
        end else begin
            rd_a_s = mem_r[raddr_a];
        end
    end

    // Read-port B select, same priority as port A
    always_comb begin
        rd_b_s = mem_r[raddr_b];
        if ((ZERO_REG != 0) && (raddr_b == {ADDR_W{1'b0}})) begin
            rd_b_s = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && wr_fire_s && (raddr_b == waddr)) begin
            rd_b_s = wdata;
        end else begin
            rd_b_s = mem_r[raddr_b];
        end
    end

    // Registered read data, one cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_r <= {DATA_W{1'b0}};
            rdata_b_r <= {DATA_W{1'b0}};
        end else begin
            rdata_a_r <= rd_a_s;
            rdata_b_r <= rd_b_s;
        end
    end

endmodule
